// File: rtl/seq_divider.sv
// Sequential restoring divider: one trial subtraction per clock, SIZE iterations per result.
// start/busy/done handshake; a start presented in the done cycle is accepted back-to-back.
module seq_divider #(
   parameter int SIZE = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [SIZE-1:0] dividend,
   input  logic [SIZE-1:0] divisor,
   output logic            busy,
   output logic            done,
   output logic [SIZE-1:0] quotient,
   output logic [SIZE-1:0] remainder,
   output logic            div_by_zero
);

   localparam int CW = $clog2(SIZE + 1);

   typedef enum logic [1:0] {IDLE, RUN, DZ, DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [SIZE:0]   r_q, r_d;
   logic [SIZE-1:0] w_q, w_d;
   logic [SIZE-1:0] dvsr_q, dvsr_d;
   logic [SIZE-1:0] quot_q, quot_d;
   logic [SIZE-1:0] rem_q, rem_d;
   logic            dbz_q, dbz_d;

   logic            accept;
   logic            last_iter;
   logic [SIZE:0]   r_shift;
   logic [SIZE:0]   trial;
   logic [SIZE:0]   r_iter;
   logic [SIZE-1:0] w_iter;

   assign accept    = start && ((state_q == IDLE) || (state_q == DONE));
   assign last_iter = (cnt_q == CW'(1));

   // One restoring step: a negative trial (MSB set) keeps the shifted remainder.
   always_comb begin
      r_shift = {r_q[SIZE-1:0], w_q[SIZE-1]};
      trial   = r_shift - {1'b0, dvsr_q};
      r_iter  = trial[SIZE] ? r_shift : trial;
      w_iter  = {w_q[SIZE-2:0], ~trial[SIZE]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = (divisor == '0) ? DZ : RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (last_iter) begin
               state_d = DONE;
            end
         end
         DZ:      state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == RUN) || (state_q == DZ);
      done = (state_q == DONE);
   end

   // Results are written only on the edge that enters DONE and otherwise hold.
   always_comb begin
      cnt_d  = cnt_q;
      r_d    = r_q;
      w_d    = w_q;
      dvsr_d = dvsr_q;
      quot_d = quot_q;
      rem_d  = rem_q;
      dbz_d  = dbz_q;
      if (accept) begin
         w_d    = dividend;
         dvsr_d = divisor;
         r_d    = '0;
         cnt_d  = CW'(SIZE);
      end else if (state_q == RUN) begin
         r_d   = r_iter;
         w_d   = w_iter;
         cnt_d = cnt_q - CW'(1);
         if (last_iter) begin
            quot_d = w_iter;
            rem_d  = r_iter[SIZE-1:0];
            dbz_d  = 1'b0;
         end
      end else if (state_q == DZ) begin
         quot_d = '1;
         rem_d  = w_q;
         dbz_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         r_q    <= '0;
         w_q    <= '0;
         dvsr_q <= '0;
         quot_q <= '0;
         rem_q  <= '0;
         dbz_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         r_q    <= r_d;
         w_q    <= w_d;
         dvsr_q <= dvsr_d;
         quot_q <= quot_d;
         rem_q  <= rem_d;
         dbz_q  <= dbz_d;
      end
   end

   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: the driver predicts results with plain / and %,
// a negedge monitor checks done timing, results, busy and result hold.
module tb_seq_divider;

   localparam int SIZE = 4;
   localparam int MAXV = (1 << SIZE) - 1;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            start = 1'b0;
   logic [SIZE-1:0] dividend = '0;
   logic [SIZE-1:0] divisor = '0;
   logic            busy;
   logic            done;
   logic [SIZE-1:0] quotient;
   logic [SIZE-1:0] remainder;
   logic            div_by_zero;

   seq_divider #(.SIZE(SIZE)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int a;
      int b;
      int q;
      int r;
      int dz;
      int c;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   free_at = 0;
   int   busy_lo = 1;
   int   busy_hi = 0;
   int   hq = 0;
   int   hr = 0;
   int   hdz = 0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One cycle of stimulus; the model decides whether the coming edge accepts it.
   task automatic drive(input bit s, input int a, input int b, output bit acc);
      int   e;
      int   lat;
      exp_t x;
      @(negedge clk);
      start    = s;
      dividend = a[SIZE-1:0];
      divisor  = b[SIZE-1:0];
      e        = cyc + 1;
      acc      = 1'b0;
      if (s && rst_n && e >= free_at) begin
         acc = 1'b1;
         lat = (b == 0) ? 2 : SIZE + 1;
         x.a = a;
         x.b = b;
         if (b == 0) begin
            x.q  = MAXV;
            x.r  = a;
            x.dz = 1;
         end else begin
            x.q  = a / b;
            x.r  = a % b;
            x.dz = 0;
         end
         x.c     = e + lat - 1;
         sb.push_back(x);
         busy_lo = e;
         busy_hi = e + lat - 2;
         free_at = e + lat;
      end
   endtask

   task automatic go(input int a, input int b);
      bit acc;
      acc = 1'b0;
      for (int n = 0; n < 64 && !acc; n++) drive(1'b1, a, b, acc);
      if (!acc) begin
         fails++;
         tests++;
         $display("FAIL accept_timeout: %0d/%0d never accepted", a, b);
      end
   endtask

   task automatic wait_idle();
      bit acc;
      for (int n = 0; n < 64 && sb.size() > 0; n++) drive(1'b0, 0, 0, acc);
      if (sb.size() > 0) begin
         fails++;
         tests++;
         $display("FAIL drain_timeout: %0d results outstanding", sb.size());
         sb.delete();
      end
      drive(1'b0, 0, 0, acc);
      drive(1'b0, 0, 0, acc);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         tests++;
         if (busy !== (cyc >= busy_lo && cyc <= busy_hi)) begin
            fails++;
            $display("FAIL busy at cycle %0d: got %0b, expected %0b", cyc, busy,
                     (cyc >= busy_lo && cyc <= busy_hi));
         end
         if (done) begin
            tests++;
            if (sb.size() == 0) begin
               fails++;
               $display("FAIL unexpected_done at cycle %0d: q=%0d r=%0d", cyc, quotient, remainder);
            end else begin
               exp_t x;
               x = sb.pop_front();
               if (quotient !== x.q[SIZE-1:0] || remainder !== x.r[SIZE-1:0] ||
                   div_by_zero !== x.dz[0] || cyc != x.c) begin
                  fails++;
                  $display("FAIL div %0d/%0d: got q=%0d r=%0d dz=%0b cyc=%0d, expected q=%0d r=%0d dz=%0d cyc=%0d",
                           x.a, x.b, quotient, remainder, div_by_zero, cyc, x.q, x.r, x.dz, x.c);
               end
               $display("[TB] %0d/%0d -> q=%0d r=%0d dz=%0b at cycle %0d", x.a, x.b,
                        quotient, remainder, div_by_zero, cyc);
               hq  = x.q;
               hr  = x.r;
               hdz = x.dz;
            end
         end else begin
            tests++;
            if (quotient !== hq[SIZE-1:0] || remainder !== hr[SIZE-1:0] || div_by_zero !== hdz[0]) begin
               fails++;
               $display("FAIL hold at cycle %0d: got q=%0d r=%0d dz=%0b, expected q=%0d r=%0d dz=%0d",
                        cyc, quotient, remainder, div_by_zero, hq, hr, hdz);
            end
            if (sb.size() > 0 && sb[0].c < cyc) begin
               exp_t x;
               x = sb.pop_front();
               tests++;
               fails++;
               $display("FAIL missing_done %0d/%0d: expected done at cycle %0d", x.a, x.b, x.c);
            end
         end
      end
   end

   initial begin
      bit acc;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_quotient", int'(quotient), 0);
      chk("reset_remainder", int'(remainder), 0);
      chk("reset_dbz", int'(div_by_zero), 0);
      rst_n = 1'b1;

      go(13, 3);
      wait_idle();

      go(15, 1);
      go(5, 7);
      go(15, 15);
      go(0, 9);
      wait_idle();

      go(9, 0);
      go(8, 2);
      wait_idle();

      // Starts while busy must be ignored; 7/7 is held until the done cycle accepts it.
      go(14, 4);
      drive(1'b1, 14, 4, acc);
      drive(1'b1, 7, 0, acc);
      go(7, 7);
      wait_idle();

      for (int a = 0; a <= MAXV; a++) begin
         for (int b = 1; b <= MAXV; b++) go(a, b);
      end
      wait_idle();

      repeat (40) begin
         go(int'($urandom_range(0, MAXV)), int'($urandom_range(0, MAXV)));
         repeat ($urandom_range(0, 3)) drive(1'b0, 0, 0, acc);
      end
      wait_idle();

      // Asynchronous reset mid-run discards the division.
      go(13, 3);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      start = 1'b0;
      #1;
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_done", int'(done), 0);
      chk("async_rst_quotient", int'(quotient), 0);
      chk("async_rst_remainder", int'(remainder), 0);
      chk("async_rst_dbz", int'(div_by_zero), 0);
      sb.delete();
      busy_lo = 1;
      busy_hi = 0;
      free_at = 0;
      hq = 0;
      hr = 0;
      hdz = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) drive(1'b0, 0, 0, acc);
      go(13, 3);
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
